// File: rtl/gpio_apb_pkg.sv
// Shared types and constants for the GPIO APB arbiter: FSM states, GPIO register
// offsets and the default address window.
package gpio_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] GPIO_LED_OFS  = 32'h0000_0000;
  localparam logic [31:0] GPIO_SW_OFS   = 32'h0000_0004;
  localparam logic [31:0] GPIO_SEG_OFS  = 32'h0000_0008;

  localparam logic [31:0] GPIO_WIN_BASE = 32'h1000_2000;
  localparam logic [31:0] GPIO_WIN_SIZE = 32'h0000_1000;

  // Unsigned wrap makes addresses below base land far above size, so one compare suffices.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/gpio_apb_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_i, cyclically.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Round-robin sharing of the GPIO APB slave port among N_REQ APB requesters,
// with local decode errors and a downstream hang watchdog.
module gpio_apb_arbiter
  import gpio_apb_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter logic [31:0] ADDR_BASE = GPIO_WIN_BASE,
  parameter logic [31:0] ADDR_SIZE = GPIO_WIN_SIZE,
  parameter int          TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     in_psel,
  input  logic [N_REQ-1:0]     in_penable,
  input  logic [N_REQ-1:0]     in_pwrite,
  input  logic [32*N_REQ-1:0]  in_paddr,
  input  logic [32*N_REQ-1:0]  in_pwdata,
  input  logic [4*N_REQ-1:0]   in_pstrb,
  input  logic [3*N_REQ-1:0]   in_pprot,
  output logic [N_REQ-1:0]     in_pready,
  output logic [31:0]          in_prdata,
  output logic                 in_pslverr,
  output logic                 out_psel,
  output logic                 out_penable,
  output logic                 out_pwrite,
  output logic [31:0]          out_paddr,
  output logic [31:0]          out_pwdata,
  output logic [3:0]           out_pstrb,
  output logic [2:0]           out_pprot,
  input  logic                 out_pready,
  input  logic [31:0]          out_prdata,
  input  logic                 out_pslverr,
  output state_e               dbg_state
);

  // Handshake: upstream follows APB (psel opens a transfer, penable marks ACCESS,
  // the transfer ends in the cycle the requester sees its in_pready bit high);
  // downstream is a strict SETUP-then-ACCESS sequence held until out_pready.

  localparam int                IDX_W    = $clog2(N_REQ);
  localparam int                WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);

  state_e           state_q;
  logic [IDX_W-1:0] last_q;
  logic [WD_W-1:0]  wd_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             write_q, err_q;
  logic [3:0]       strb_q;
  logic [2:0]       prot_q;
  logic             out_psel_q, out_penable_q;

  logic [N_REQ-1:0] win_grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [31:0]      win_addr_d, win_wdata_d;
  logic             win_write_d;
  logic [3:0]       win_strb_d;
  logic [2:0]       win_prot_d;
  logic             resp_hit;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (in_psel),
    .last_i  (last_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    win_addr_d  = '0;
    win_wdata_d = '0;
    win_write_d = 1'b0;
    win_strb_d  = '0;
    win_prot_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_grant[i]) begin
        win_addr_d  = in_paddr[32*i +: 32];
        win_wdata_d = in_pwdata[32*i +: 32];
        win_write_d = in_pwrite[i];
        win_strb_d  = in_pstrb[4*i +: 4];
        win_prot_d  = in_pprot[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      last_q        <= LAST_RST;
      wd_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      strb_q        <= '0;
      prot_q        <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            addr_q  <= win_addr_d;
            wdata_q <= win_wdata_d;
            write_q <= win_write_d;
            strb_q  <= win_strb_d;
            prot_q  <= win_prot_d;
            last_q  <= win_idx;
            if (addr_in_window(win_addr_d, ADDR_BASE, ADDR_SIZE)) begin
              state_q    <= ST_SETUP;
              out_psel_q <= 1'b1;
            end else begin
              state_q <= ST_RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ST_SETUP: begin
          state_q       <= ST_ACCESS;
          out_penable_q <= 1'b1;
          wd_q          <= '0;
        end
        ST_ACCESS: begin
          if (out_pready) begin
            rdata_q       <= out_prdata;
            err_q         <= out_pslverr;
            out_psel_q    <= 1'b0;
            out_penable_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if (wd_q == WD_LAST) begin
            // Slave never answered: abandon the bus and report an error upstream.
            rdata_q       <= '0;
            err_q         <= 1'b1;
            out_psel_q    <= 1'b0;
            out_penable_q <= 1'b0;
            state_q       <= ST_RESP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ST_RESP: begin
          if (in_penable[last_q]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response is steered combinationally so it lands in the requester's ACCESS cycle.
  always_comb begin
    resp_hit   = (state_q == ST_RESP) && in_penable[last_q];
    in_pready  = '0;
    in_prdata  = '0;
    in_pslverr = 1'b0;
    if (resp_hit) begin
      in_pready[last_q] = 1'b1;
      in_prdata         = rdata_q;
      in_pslverr        = err_q;
    end
  end

  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_pwrite  = write_q;
  assign out_paddr   = addr_q;
  assign out_pwdata  = wdata_q;
  assign out_pstrb   = strb_q;
  assign out_pprot   = prot_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Bench for gpio_apb_arbiter: vector table, hand sequences and random traffic
// checked against a transaction-level reference model.
module tb_gpio_apb_arbiter;
  import gpio_apb_pkg::*;

  localparam int          N       = 2;
  localparam int          TMO     = 4;
  localparam logic [31:0] WBASE   = 32'h1000_2000;
  localparam logic [31:0] WSIZE   = 32'h0000_1000;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    in_psel, in_penable, in_pwrite, in_pready;
  logic [32*N-1:0] in_paddr, in_pwdata;
  logic [4*N-1:0]  in_pstrb;
  logic [3*N-1:0]  in_pprot;
  logic [31:0]     in_prdata, out_paddr, out_pwdata, out_prdata;
  logic            in_pslverr, out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [3:0]      out_pstrb;
  logic [2:0]      out_pprot;
  state_e          dbg_state;

  gpio_apb_arbiter #(.N_REQ(N), .ADDR_BASE(WBASE), .ADDR_SIZE(WSIZE), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn),
    .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
    .in_paddr(in_paddr), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pprot(in_pprot),
    .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_pprot(out_pprot),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400us");
    $fatal(1);
  end

  // ---------------- requester drive ----------------
  logic        r_psel[N], r_penable[N], r_pwrite[N];
  logic [31:0] r_paddr[N], r_pwdata[N];
  logic [3:0]  r_pstrb[N];
  logic [2:0]  r_pprot[N];

  always_comb begin
    in_psel = '0; in_penable = '0; in_pwrite = '0;
    in_paddr = '0; in_pwdata = '0; in_pstrb = '0; in_pprot = '0;
    for (int i = 0; i < N; i++) begin
      in_psel[i] = r_psel[i];
      in_penable[i] = r_penable[i];
      in_pwrite[i] = r_pwrite[i];
      in_paddr[32*i +: 32] = r_paddr[i];
      in_pwdata[32*i +: 32] = r_pwdata[i];
      in_pstrb[4*i +: 4] = r_pstrb[i];
      in_pprot[3*i +: 3] = r_pprot[i];
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] order_q[$];
  int model_last = N - 1;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          cyc;
  } dn_t;
  dn_t dn_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- downstream slave + bus monitor ----------------
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          acc_k = 0;
  logic        prev_acc = 1'b0, prev_setup = 1'b0, prev_psel = 1'b0;

  initial begin
    out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
  end

  always @(posedge clock) begin
    #1;
    if (out_psel && !out_penable) begin
      check("psel_gap", 32'(prev_psel), 32'd0);
      dn_q.push_back('{out_paddr, out_pwrite, out_pwdata, out_pstrb, out_pprot, cyc});
    end
    if (out_psel && out_penable) begin
      if (!prev_acc) begin
        check("setup_then_access", 32'(prev_setup), 32'd1);
        acc_k = 0;
      end else begin
        acc_k++;
      end
      prev_acc = 1'b1;
    end else begin
      prev_acc = 1'b0;
    end
    out_pready  = out_psel && out_penable && (acc_k >= slv_wait);
    out_prdata  = slv_rdata;
    out_pslverr = slv_err;
    prev_setup  = out_psel && !out_penable;
    prev_psel   = out_psel;
  end

  always @(negedge clock) begin
    check("pready_onehot0", 32'($onehot0(in_pready)), 32'd1);
    if (in_pready == '0) check("idle_resp_zero", {in_prdata[31:1], in_prdata[0] | in_pslverr}, 32'd0);
  end

  // ---------------- reference model ----------------
  function automatic logic bench_in_window(input logic [31:0] addr);
    return (64'(addr) >= 64'(WBASE)) && (64'(addr) < 64'(WBASE) + 64'(WSIZE));
  endfunction

  task automatic ref_model(input logic [31:0] addr, input int swait, input logic [31:0] srdata,
                           input logic serr, output logic err, output logic [31:0] rdata,
                           output int lat);
    if (!bench_in_window(addr)) begin
      err = 1'b1; rdata = '0; lat = 1;
    end else if (swait >= TMO) begin
      err = 1'b1; rdata = '0; lat = 2 + TMO;
    end else begin
      err = serr; rdata = srdata; lat = 3 + swait;
    end
  endtask

  // Expected service order when every listed request is pending at each arbitration.
  task automatic build_exp(input int c0, input int c1);
    int cnt[N];
    cnt[0] = c0; cnt[1] = c1;
    while (cnt[0] + cnt[1] > 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (model_last + k) % N;
        if (cnt[j] > 0) begin
          exp_q.push_back(2'(j));
          cnt[j]--;
          model_last = j;
          break;
        end
      end
    end
  endtask

  task automatic check_order(input string name);
    logic [1:0] e, a;
    check({name, "_len"}, 32'(order_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (order_q.size() > 0) ? order_q.pop_front() : 2'd3;
      check(name, 32'(a), 32'(e));
    end
    order_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 with this requester's psel released.
  task automatic xfer(input int i, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int   start, lat;
    logic ok;
    dn_t  d;
    start = cyc; ok = 1'b0; lat = -1;
    r_psel[i] = 1'b1; r_penable[i] = 1'b0; r_pwrite[i] = wr;
    r_paddr[i] = addr; r_pwdata[i] = wdata; r_pstrb[i] = strb; r_pprot[i] = prot;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (in_pready[i]) begin
        check("rdata", in_prdata, exp_rdata);
        check("pslverr", 32'(in_pslverr), 32'(exp_err));
        lat = c; ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      r_penable[i] = 1'b1;
    end
    check("xfer_done", 32'(ok), 32'd1);
    if (ok) begin
      order_q.push_back(2'(i));
      if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
      if (bench_in_window(addr)) begin
        if (dn_q.size() == 0) begin
          check("dn_present", 32'd0, 32'd1);
        end else begin
          d = dn_q.pop_front();
          check("dn_addr", d.addr, addr);
          check("dn_write", 32'(d.wr), 32'(wr));
          check("dn_wdata", d.wdata, wdata);
          check("dn_strb_prot", {25'd0, d.strb, d.prot}, {25'd0, strb, prot});
          if (exp_lat >= 0) check("setup_cycle", 32'(d.cyc - start), 32'd1);
        end
      end else begin
        check("oow_no_dn", 32'(dn_q.size()), 32'd0);
      end
    end
    @(posedge clock); #1;
    r_psel[i] = 1'b0; r_penable[i] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          swait;
    logic [31:0] srdata;
    logic        serr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs[8];

  logic        e0, e1;
  logic [31:0] d0, d1, a0, a1, w0, w1;
  int          l0, l1, mode;

  initial begin
    for (int i = 0; i < N; i++) begin
      r_psel[i] = 1'b0; r_penable[i] = 1'b0; r_pwrite[i] = 1'b0;
      r_paddr[i] = '0; r_pwdata[i] = '0; r_pstrb[i] = '0; r_pprot[i] = '0;
    end
    vecs[0] = '{0, 1'b1, 32'h1000_2000, 32'h0000_A5A5, 4'b0011, 0, 32'h0,         1'b0, 1'b0, 32'h0,         3};
    vecs[1] = '{1, 1'b0, 32'h1000_2004, 32'h0,         4'b0000, 0, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_1234, 3};
    vecs[2] = '{0, 1'b0, 32'h1000_2008, 32'h0,         4'b0000, 2, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 5};
    vecs[3] = '{0, 1'b0, 32'h1000_3000, 32'h0,         4'b0000, 0, 32'h5555_5555, 1'b0, 1'b1, 32'h0,         1};
    vecs[4] = '{1, 1'b1, 32'h1000_2FFC, 32'h1357_9BDF, 4'b1111, 3, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_0077, 6};
    vecs[5] = '{1, 1'b1, 32'h1000_1FFC, 32'h2468_ACE0, 4'b1000, 0, 32'h0,         1'b0, 1'b1, 32'h0,         1};
    vecs[6] = '{0, 1'b0, 32'h1000_2004, 32'h0,         4'b0000, 9, 32'h0000_ABCD, 1'b0, 1'b1, 32'h0,         6};
    vecs[7] = '{1, 1'b0, 32'h1000_2000, 32'h0,         4'b0000, 0, 32'h0000_000F, 1'b0, 1'b0, 32'h0000_000F, 3};

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_ctrl", {29'd0, out_psel, out_penable, out_pwrite}, 32'd0);
    check("rst_out_paddr", out_paddr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    @(posedge clock); #1;

    // table
    for (int v = 0; v < 8; v++) begin
      slv_wait = vecs[v].swait; slv_rdata = vecs[v].srdata; slv_err = vecs[v].serr;
      xfer(vecs[v].req, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 3'(v),
           vecs[v].exp_err, vecs[v].exp_rdata, vecs[v].exp_lat);
      exp_q.push_back(2'(vecs[v].req));
      model_last = vecs[v].req;
    end
    check_order("table_order");

    // simultaneous reads of the switch register
    slv_wait = 0; slv_rdata = 32'h0000_1234; slv_err = 1'b0;
    build_exp(1, 1);
    fork
      xfer(0, 1'b0, WBASE + GPIO_SW_OFS, 32'h0, 4'h0, 3'd0, 1'b0, 32'h1234, -1);
      xfer(1, 1'b0, WBASE + GPIO_SW_OFS, 32'h0, 4'h0, 3'd1, 1'b0, 32'h1234, -1);
    join
    check_order("simul_order");

    // fairness: both keep requesting back to back
    slv_wait = 1; slv_rdata = 32'h0000_0042;
    build_exp(3, 3);
    fork
      begin
        for (int k = 0; k < 3; k++)
          xfer(0, 1'b1, WBASE + GPIO_LED_OFS, 32'h100 + k, 4'hF, 3'd2, 1'b0, 32'h42, -1);
      end
      begin
        for (int k = 0; k < 3; k++)
          xfer(1, 1'b1, WBASE + GPIO_SEG_OFS, 32'h200 + k, 4'h1, 3'd4, 1'b0, 32'h42, -1);
      end
    join
    check_order("fair_order");

    // reset in the middle of ACCESS
    slv_wait = 50;
    r_psel[0] = 1'b1; r_pwrite[0] = 1'b1; r_paddr[0] = WBASE + GPIO_SEG_OFS;
    r_pwdata[0] = 32'hFEED_F00D; r_pstrb[0] = 4'hF; r_pprot[0] = 3'd5;
    @(posedge clock); #1;
    r_penable[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (dbg_state == ST_ACCESS) break;
    end
    check("reach_access", 32'(dbg_state), 32'(ST_ACCESS));
    @(negedge clock); #2;
    resetn = 1'b0;
    #1;
    check("arst_out_ctrl", {29'd0, out_psel, out_penable, out_pwrite}, 32'd0);
    check("arst_out_paddr", out_paddr, 32'd0);
    check("arst_out_pwdata", out_pwdata, 32'd0);
    check("arst_out_strb_prot", {25'd0, out_pstrb, out_pprot}, 32'd0);
    check("arst_in_pready", 32'(in_pready), 32'd0);
    check("arst_in_resp", {in_prdata[31:1], in_prdata[0] | in_pslverr}, 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    r_psel[0] = 1'b0; r_penable[0] = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    dn_q.delete();
    model_last = N - 1;
    @(posedge clock); #1;
    slv_wait = 0; slv_rdata = 32'h0000_C0DE; slv_err = 1'b0;
    build_exp(1, 1);
    fork
      xfer(1, 1'b0, WBASE + GPIO_SW_OFS, 32'h0, 4'h0, 3'd0, 1'b0, 32'hC0DE, -1);
      xfer(0, 1'b0, WBASE + GPIO_SW_OFS, 32'h0, 4'h0, 3'd0, 1'b0, 32'hC0DE, 3);
    join
    check_order("post_reset_order");

    // random traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      slv_wait = $urandom_range(0, 5);
      slv_rdata = $urandom();
      slv_err = 1'($urandom_range(0, 1));
      a0 = ($urandom_range(0, 3) != 0) ? WBASE + 32'($urandom_range(0, 1023) << 2) : $urandom();
      a1 = ($urandom_range(0, 3) != 0) ? WBASE + 32'($urandom_range(0, 1023) << 2) : $urandom();
      w0 = $urandom(); w1 = $urandom();
      ref_model(a0, slv_wait, slv_rdata, slv_err, e0, d0, l0);
      ref_model(a1, slv_wait, slv_rdata, slv_err, e1, d1, l1);
      if (mode == 0) begin
        build_exp(1, 0);
        xfer(0, 1'b1, a0, w0, 4'($urandom()), 3'($urandom()), e0, d0, l0);
      end else if (mode == 1) begin
        build_exp(0, 1);
        xfer(1, 1'b0, a1, w1, 4'($urandom()), 3'($urandom()), e1, d1, l1);
      end else begin
        build_exp(1, 1);
        fork
          xfer(0, 1'b0, a0, w0, 4'h3, 3'd1, e0, d0, -1);
          xfer(1, 1'b1, a1, w1, 4'hC, 3'd6, e1, d1, -1);
        join
      end
      check_order("rand_order");
    end

    repeat (3) @(posedge clock);
    check("dn_leftover", 32'(dn_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
